hall_count_scheduler: RTL and testbench
=======================================

HALL_COUNT_SCHEDULER -- requirements
Module: hall_count_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of hall counter channels (2..8).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 8, width of each hall counter value.
REQ-003 SHALL have parameter PERIOD, default 1000, sample period in clk cycles (>= NUM_CH+2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-006 SHALL have port enable  input  1  level; 1 = scheduling active.
REQ-007 SHALL have port count_in  input  NUM_CH*COUNTER_WIDTH  live counter values; channel i in bits [i*W +: W].
REQ-008 SHALL have port cnt_reset  output  NUM_CH  synchronous clear pulses to the counters.
REQ-009 SHALL have port out_valid  output  1  delta word valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts word when out_valid&&out_ready.
REQ-011 SHALL have port out_ch  output  3  channel index of the current word.
REQ-012 SHALL have port out_delta  output  COUNTER_WIDTH  signed two's-complement step delta for out_ch.
REQ-013 SHALL have port out_last  output  1  high on the word for channel NUM_CH-1.
REQ-014 SHALL have port out_seq  output  8  frame sequence number, constant within a frame.
REQ-015 SHALL have port overrun  output  1  sticky: a tick was dropped.
REQ-016 SHALL have port ovr_clr  input  1  one-cycle clear of overrun.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, WAIT, EMIT.
REQ-018 IDLE: stay while enable=0; enable=1 -> CLEAR next cycle.
REQ-019 CLEAR (exactly 1 cycle): cnt_reset all-ones, prev[i]=0, tick timer loaded with PERIOD-1 -> WAIT.
REQ-020 Timer SHALL decrement every cycle in WAIT and EMIT; tick when timer==0; reload to PERIOD-1 on the tick cycle, giving one tick every PERIOD cycles.
REQ-021 Tick in WAIT: snap[i] captures count_in for all channels on the same edge, idx=0, out_seq increments (mod 256), -> EMIT; out_valid high the following cycle.
REQ-022 EMIT: out_valid=1, out_ch=idx, out_delta=(snap[idx]-prev[idx]) mod 2^COUNTER_WIDTH, out_last=(idx==NUM_CH-1); outputs held stable until handshake.
REQ-023 On handshake: prev[idx]<=snap[idx], idx++; after last-channel handshake -> WAIT.
REQ-024 Tick in EMIT before the last handshake SHALL be dropped: snap unchanged, out_seq unchanged, overrun set; the next accepted frame's delta spans both periods (no counts lost).
REQ-025 Tick coinciding with the last-channel handshake SHALL be accepted: snap recaptured, idx=0, out_seq increments, remain in EMIT, no overrun.
REQ-026 Wrap-around: counter wrap is absorbed by modular subtraction; delta interpreted as signed (e.g. prev=0xFE, snap=0x03 -> +5; prev=0x02, snap=0xFD -> -5 for W=8).
REQ-027 enable=0 in any state SHALL go to IDLE next cycle, aborting any frame; out_valid deasserts that next cycle.
REQ-028 overrun: set on dropped tick, cleared by ovr_clr; simultaneous set and clear -> set wins.
REQ-029 cnt_reset SHALL be high only in CLEAR, registered, never combinational from inputs.

Reset
REQ-030 reset SHALL force state IDLE, cnt_reset=0, out_valid=0, out_ch=0, out_delta=0, out_last=0, out_seq=0, overrun=0, idx=0, timer=PERIOD-1, snap/prev=0.
REQ-031 reset SHALL take priority over all other inputs including enable and handshake; re-entering operation always passes through CLEAR.

Structure
REQ-032 State encoding, channel-index width and signed-delta helper constants SHALL live in shared package hall_sched_pkg.
REQ-033 The period timer SHALL be sub-module hall_tick_timer (load, run, tick outputs); the single subtractor is shared across channels via idx.

Verification
REQ-034 Basic: NUM_CH=5, PERIOD=20, enable at t0, counters advance ch0..ch4 by 1,2,3,4,5, out_ready=1 -> cnt_reset pulse in cycle 1, frame words deltas 1..5, out_last on ch4, out_seq=1.
REQ-035 Wrap: ch0 count 0xFE at tick1, 0x03 at tick2 -> ch0 delta +5 (0x05); reverse rotation 0x02->0xFD -> 0xFB.
REQ-036 Backpressure/overrun: out_ready=0 for 25 cycles with PERIOD=20 -> overrun=1, out_seq does not increment for dropped tick, next frame delta equals sum over two periods; ovr_clr clears.
REQ-037 Coincident tick and last handshake: time out_ready so ch4 accepted on tick cycle -> new frame starts next cycle, out_seq+1, overrun stays 0.
REQ-038 Abort: enable=0 mid-frame at ch2 -> out_valid=0 next cycle, IDLE; enable=1 -> fresh cnt_reset pulse, deltas restart from 0.
REQ-039 Reset mid-EMIT with out_valid=1 -> all outputs at reset values next cycle, state IDLE.

Source files
------------

// File: rtl/hall_sched_pkg.sv
// Shared types and constants for the hall counter sampling scheduler.
package hall_sched_pkg;

   // Scheduler states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_WAIT  = 2'd2,
      ST_EMIT  = 2'd3
   } sched_state_e;

   // Channel index width; covers up to 8 channels and matches out_ch.
   localparam int CH_IDX_W = 3;

   // Frame sequence number width.
   localparam int SEQ_W = 8;

   // Deltas are plain modular differences of the raw counter values, read
   // back as two's complement: one counter width is enough to absorb a
   // single wrap in either rotation direction.
   localparam int DELTA_SIGN_BIT_OFS = 1;

   // Index of the last channel in a frame.
   function automatic logic [CH_IDX_W-1:0] last_idx(input int num_ch);
      return CH_IDX_W'(num_ch - 1);
   endfunction

endpackage

// File: rtl/hall_tick_timer.sv
// Sample-period down-counter. Fires tick_o on the cycle the count reaches
// zero while running and reloads on that same cycle, so ticks are PERIOD
// cycles apart.
module hall_tick_timer #(
   parameter int PERIOD = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic run_i,
   output logic tick_o
);

   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(PERIOD - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   assign tick_o = run_i && (cnt_q == '0);

   // Next count: explicit load wins, otherwise count down and reload on tick.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = RELOAD;
      end else if (run_i) begin
         if (cnt_q == '0) begin
            cnt_d = RELOAD;
         end else begin
            cnt_d = cnt_q - TW'(1);
         end
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hall_count_scheduler.sv
// Periodically snapshots a bank of free-running hall counters and streams
// one signed delta word per channel through a valid/ready port.
//
// state    | meaning
// ---------|------------------------------------------------------------
// ST_IDLE  | scheduling off, waiting for enable
// ST_CLEAR | one cycle: clear counters and prev values, load period timer
// ST_WAIT  | timer running, waiting for the next sample tick
// ST_EMIT  | presenting channel idx delta, advancing on each handshake
module hall_count_scheduler
   import hall_sched_pkg::*;
#(
   parameter int NUM_CH        = 5,
   parameter int COUNTER_WIDTH = 8,
   parameter int PERIOD        = 1000
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              enable,
   input  logic [NUM_CH*COUNTER_WIDTH-1:0]   count_in,
   output logic [NUM_CH-1:0]                 cnt_reset,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [2:0]                        out_ch,
   output logic [COUNTER_WIDTH-1:0]          out_delta,
   output logic                              out_last,
   output logic [SEQ_W-1:0]                  out_seq,
   output logic                              overrun,
   input  logic                              ovr_clr
);

   localparam int W = COUNTER_WIDTH;
   localparam logic [CH_IDX_W-1:0] LAST_IDX = last_idx(NUM_CH);

   sched_state_e              state_q, state_d;
   logic [CH_IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_CH*W-1:0]       snap_q, snap_d;
   logic [NUM_CH*W-1:0]       prev_q, prev_d;
   logic [SEQ_W-1:0]          seq_q, seq_d;
   logic                      overrun_q, overrun_d;
   logic [NUM_CH-1:0]         cnt_reset_q;

   logic                      tmr_load;
   logic                      tmr_run;
   logic                      tick;
   logic                      ovr_set;
   logic                      hs;
   logic                      at_last;
   logic [W-1:0]              snap_sel;
   logic [W-1:0]              prev_sel;
   logic [W-1:0]              sel_delta;

   hall_tick_timer #(
      .PERIOD (PERIOD)
   ) u_tick_timer (
      .clk    (clk),
      .reset  (reset),
      .load_i (tmr_load),
      .run_i  (tmr_run),
      .tick_o (tick)
   );

   // One subtractor shared by all channels, steered by idx.
   assign snap_sel  = snap_q[idx_q*W +: W];
   assign prev_sel  = prev_q[idx_q*W +: W];
   assign sel_delta = snap_sel - prev_sel;

   assign hs      = (state_q == ST_EMIT) && out_ready;
   assign at_last = (idx_q == LAST_IDX);

   // Next-state, frame bookkeeping and tick handling.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      snap_d   = snap_q;
      prev_d   = prev_q;
      seq_d    = seq_q;
      tmr_load = 1'b0;
      tmr_run  = (state_q == ST_WAIT) || (state_q == ST_EMIT);
      ovr_set  = 1'b0;

      if (!enable) begin
         // Abort whatever is in flight; restart always goes through CLEAR.
         state_d = ST_IDLE;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
               prev_d   = '0;
               idx_d    = '0;
               tmr_load = 1'b1;
               state_d  = ST_WAIT;
            end
            ST_WAIT: begin
               if (tick) begin
                  snap_d  = count_in;
                  idx_d   = '0;
                  seq_d   = seq_q + SEQ_W'(1);
                  state_d = ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (hs) begin
                  prev_d[idx_q*W +: W] = snap_sel;
                  if (at_last) begin
                     idx_d = '0;
                     if (tick) begin
                        // Back-to-back frame: the tick lands on the final
                        // handshake, so it can be taken without losing data.
                        snap_d = count_in;
                        seq_d  = seq_q + SEQ_W'(1);
                     end else begin
                        state_d = ST_WAIT;
                     end
                  end else begin
                     idx_d = idx_q + CH_IDX_W'(1);
                  end
               end
               // A tick that cannot be taken leaves snap alone, so the
               // following frame's deltas cover both periods.
               if (tick && !(hs && at_last)) begin
                  ovr_set = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (ovr_set) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         snap_q      <= '0;
         prev_q      <= '0;
         seq_q       <= '0;
         overrun_q   <= 1'b0;
         cnt_reset_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         prev_q      <= prev_d;
         seq_q       <= seq_d;
         overrun_q   <= overrun_d;
         cnt_reset_q <= {NUM_CH{state_d == ST_CLEAR}};
      end
   end

   assign cnt_reset = cnt_reset_q;
   assign out_valid = (state_q == ST_EMIT);
   assign out_ch    = idx_q;
   assign out_delta = out_valid ? sel_delta : '0;
   assign out_last  = out_valid && at_last;
   assign out_seq   = seq_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_hall_count_scheduler.sv
// Directed bench for hall_count_scheduler with NUM_CH=5, W=8, PERIOD=20.
module tb_hall_count_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [39:0] count_in;
   logic [4:0]  cnt_reset;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_ch;
   logic [7:0]  out_delta;
   logic        out_last;
   logic [7:0]  out_seq;
   logic        overrun;
   logic        ovr_clr;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   hall_count_scheduler #(
      .NUM_CH        (5),
      .COUNTER_WIDTH (8),
      .PERIOD        (20)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .count_in  (count_in),
      .cnt_reset (cnt_reset),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_delta (out_delta),
      .out_last  (out_last),
      .out_seq   (out_seq),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("valid_seen", 32'(out_valid), 1);
   endtask

   // Consume one frame; optionally stall first, and preload next counts.
   task automatic run_frame(input logic [39:0] want_d, input int seq, input int stall,
                            input logic [39:0] next_cnt);
      int n;
      wait_valid(n);
      count_in = next_cnt;
      if (stall > 0) begin
         out_ready = 1'b0;
         repeat (stall) @(negedge clk);
         out_ready = 1'b1;
      end
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("w%0d_valid", i), 32'(out_valid), 1);
         chk($sformatf("w%0d_ch", i), 32'(out_ch), i);
         chk($sformatf("w%0d_delta", i), 32'(out_delta), 32'(want_d[i*8 +: 8]));
         chk($sformatf("w%0d_last", i), 32'(out_last), (i == 4) ? 1 : 0);
         if (seq >= 0) chk($sformatf("w%0d_seq", i), 32'(out_seq), seq);
         @(negedge clk);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_cnt_reset"}, 32'(cnt_reset), 0);
      chk({tag, "_ch"}, 32'(out_ch), 0);
      chk({tag, "_delta"}, 32'(out_delta), 0);
      chk({tag, "_last"}, 32'(out_last), 0);
      chk({tag, "_seq"}, 32'(out_seq), 0);
      chk({tag, "_overrun"}, 32'(overrun), 0);
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      enable    = 1'b0;
      out_ready = 1'b1;
      ovr_clr   = 1'b0;
      count_in  = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("por");

      // Basic frame: counters ch0..ch4 at 1..5.
      reset    = 1'b0;
      enable   = 1'b1;
      count_in = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      @(negedge clk);
      chk("clear_pulse", 32'(cnt_reset), 32'h1F);
      @(negedge clk);
      chk("clear_end", 32'(cnt_reset), 0);
      wait_valid(n);
      chk("first_latency", 32'(n), 20);
      run_frame({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 1, 0, {8'd5, 8'd4, 8'd3, 8'd2, 8'hFE});
      chk("f1_done_valid", 32'(out_valid), 0);

      // Wrap handling in both rotation directions on ch0.
      run_frame({8'd0, 8'd0, 8'd0, 8'd0, 8'hFD}, 2, 0, {8'd5, 8'd4, 8'd3, 8'd12, 8'h03});
      run_frame({8'd0, 8'd0, 8'd0, 8'd10, 8'h05}, 3, 0, {8'd5, 8'd4, 8'd3, 8'd12, 8'h02});
      run_frame({8'd0, 8'd0, 8'd0, 8'd0, 8'hFF}, 4, 0, {8'd5, 8'd4, 8'd3, 8'd12, 8'hFD});
      run_frame({8'd0, 8'd0, 8'd0, 8'd0, 8'hFB}, 5, 0, {8'd5, 8'd4, 8'd5, 8'd13, 8'h00});

      // Backpressure: 25-cycle stall drops one tick.
      run_frame({8'd0, 8'd0, 8'd2, 8'd1, 8'h03}, 6, 25, {8'd9, 8'd4, 8'd5, 8'd20, 8'h10});
      chk("ovr_set", 32'(overrun), 1);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      chk("ovr_cleared", 32'(overrun), 0);

      // Frame spanning two periods, with ch4 accepted on the tick edge.
      run_frame({8'd4, 8'd0, 8'd0, 8'd7, 8'h10}, 7, 15, {8'd9, 8'd4, 8'd5, 8'd20, 8'h11});
      chk("coinc_valid", 32'(out_valid), 1);
      chk("coinc_ch", 32'(out_ch), 0);
      chk("coinc_seq", 32'(out_seq), 8);
      chk("coinc_ovr", 32'(overrun), 0);
      run_frame({8'd0, 8'd0, 8'd0, 8'd0, 8'h01}, 8, 0, {8'd9, 8'd4, 8'd5, 8'd22, 8'h15});
      chk("f8_done_valid", 32'(out_valid), 0);

      // Abort mid-frame at ch2.
      wait_valid(n);
      chk("ab_seq", 32'(out_seq), 9);
      chk("ab_d0", 32'(out_delta), 4);
      @(negedge clk);
      chk("ab_d1", 32'(out_delta), 2);
      @(negedge clk);
      chk("ab_ch2", 32'(out_ch), 2);
      enable = 1'b0;
      @(negedge clk);
      chk("ab_valid_off", 32'(out_valid), 0);
      @(negedge clk);
      chk("ab_idle_valid", 32'(out_valid), 0);
      enable   = 1'b1;
      count_in = {8'd0, 8'd1, 8'd7, 8'd0, 8'd3};
      @(negedge clk);
      chk("ab_clear_pulse", 32'(cnt_reset), 32'h1F);
      run_frame({8'd0, 8'd1, 8'd7, 8'd0, 8'd3}, -1, 0, {8'd0, 8'd1, 8'd7, 8'd0, 8'd5});

      // Reset while a word is being offered.
      wait_valid(n);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("mid_rst");
      reset = 1'b0;
      @(negedge clk);
      chk("rst_reclear", 32'(cnt_reset), 32'h1F);
      chk("rst_reclear_valid", 32'(out_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
